// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART-to-ALU command sequencer.
// Counter width helper is used only when UART_ALU_TIMEOUT_EN is defined.
package uart_alu_pkg;

    localparam int DEF_NB_DATA        = 8;
    localparam int DEF_NB_OP          = 6;
    localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    // Bits needed to count 0 .. cycles-1, never less than one.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    localparam int DEF_NB_CNT = cnt_width(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/uart_alu_timeout.sv
// Clearable, enabled inter-byte counter; pulses o_expire on its last count.
// A clear in the expiry cycle wins, so a late byte never raises an error.
module uart_alu_timeout
    import uart_alu_pkg::*;
#(
    parameter int NB_CNT         = DEF_NB_CNT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    logic [NB_CNT-1:0] r_cnt;

    assign o_expire = i_en && !i_clr && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || i_clr || !i_en || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_intf.sv
// Assembles A, B, opcode from received bytes, latches the ALU result and
// starts the transmitter. Optional inter-byte timeout: UART_ALU_TIMEOUT_EN.
module uart_alu_intf
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = DEF_NB_DATA,
    parameter int NB_OP          = DEF_NB_OP,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               tx_done_tick,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    output logic               timeout_err,
    output logic [2:0]         dbg_state
);

    state_t             r_state;
    state_t             w_next_state;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_timeout_err;
    logic               w_cap_a;
    logic               w_cap_b;
    logic               w_cap_op;
    logic               w_send;
    logic               w_expire;

    // Bytes are accepted only in the three collection states.
    assign w_cap_a  = (r_state == ST_WAIT_A)  && rx_done_tick;
    assign w_cap_b  = (r_state == ST_WAIT_B)  && rx_done_tick;
    assign w_cap_op = (r_state == ST_WAIT_OP) && rx_done_tick;
    assign w_send   = (r_state == ST_SEND);

`ifdef UART_ALU_TIMEOUT_EN
    localparam int NB_CNT = cnt_width(TIMEOUT_CYCLES);

    logic w_cnt_en;
    logic w_cnt_clr;

    assign w_cnt_en  = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_cnt_clr = w_cap_a || w_cap_b || w_cap_op;

    uart_alu_timeout #(
        .NB_CNT         (NB_CNT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );
`else
    // Without the timeout feature TIMEOUT_CYCLES has no effect.
    assign w_expire = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT_A:  if (rx_done_tick) w_next_state = ST_WAIT_B;
            ST_WAIT_B:  begin
                if (rx_done_tick)  w_next_state = ST_WAIT_OP;
                else if (w_expire) w_next_state = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (rx_done_tick)  w_next_state = ST_SEND;
                else if (w_expire) w_next_state = ST_WAIT_A;
            end
            ST_SEND:    w_next_state = ST_WAIT_TX;
            ST_WAIT_TX: if (tx_done_tick) w_next_state = ST_WAIT_A;
            default:    w_next_state = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_WAIT_A;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= '0;
            r_tx_data     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_timeout_err <= w_expire;
            if (w_cap_a)  r_alu_a   <= rx_data;
            if (w_cap_b)  r_alu_b   <= rx_data;
            if (w_cap_op) r_alu_op  <= rx_data[NB_OP-1:0];
            if (w_send)   r_tx_data <= alu_result;
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign tx_data     = r_tx_data;
    assign tx_start    = w_send;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed bench for uart_alu_intf with a scoreboard on tx_start.
// Define UART_ALU_TIMEOUT_EN for both RTL and bench to cover the timeout.
module tb_uart_alu_intf;
    import uart_alu_pkg::*;

    localparam int TO_CYCLES = 16;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] alu_result;
    logic       tx_done_tick = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       timeout_err;
    logic [2:0] dbg_state;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   to_pulses = 0;

    uart_alu_intf #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .alu_result   (alu_result),
        .tx_done_tick (tx_done_tick),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .timeout_err  (timeout_err),
        .dbg_state    (dbg_state)
    );

    // Clock and reference ALU
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    always @(negedge clk) if (timeout_err) to_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks: entered and left at posedge + 1
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        idle(1);
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done_tick = 1'b1;
        idle(1);
        tx_done_tick = 1'b0;
    endtask

    task automatic command(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op_byte, input logic [5:0] op,
                           input logic [7:0] res);
        exp_q.push_back('{a: a, b: b, op: op, res: res});
        send_byte(a);
        send_byte(b);
        send_byte(op_byte);
        idle(2);
        pulse_tx_done();
    endtask

    // Monitor: each tx_start pops one expected command
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    check("tx_start_width", 32'(tx_start), 32'd0);
                    check("tx_data", 32'(tx_data), 32'(e.res));
                    check("alu_a", 32'(alu_a), 32'(e.a));
                    check("alu_b", 32'(alu_b), 32'(e.b));
                    check("alu_op", 32'(alu_op), 32'(e.op));
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int p0;
        idle(3);
        reset = 1'b0;
        check("rst_state", 32'(dbg_state), 32'(ST_WAIT_A));
        check("rst_alu_a", 32'(alu_a), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);

        // 0x05 + 0x03; extra byte during SEND is dropped
        exp_q.push_back('{a: 8'h05, b: 8'h03, op: 6'h20, res: 8'h08});
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        send_byte(8'h77);
        idle(1);
        check("hold_alu_a", 32'(alu_a), 32'h05);
        check("hold_state", 32'(dbg_state), 32'(ST_WAIT_TX));
        pulse_tx_done();
        check("after_tx_done", 32'(dbg_state), 32'(ST_WAIT_A));

        // Upper opcode bits dropped: 0xE4 -> 0x24 (AND)
        exp_q.push_back('{a: 8'h0F, b: 8'h3C, op: 6'h24, res: 8'h0C});
        send_byte(8'h0F);
        send_byte(8'h3C);
        send_byte(8'hE4);
        idle(2);
        send_byte(8'hAA);
        pulse_tx_done();
        command(8'h01, 8'h02, 8'h20, 6'h20, 8'h03);

        // Reset mid-command
        send_byte(8'h11);
        send_byte(8'h22);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_WAIT_A));
        check("mid_rst_alu_a", 32'(alu_a), 32'h0);
        check("mid_rst_alu_b", 32'(alu_b), 32'h0);
        check("mid_rst_alu_op", 32'(alu_op), 32'h0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h0);
        check("mid_rst_tx_start", 32'(tx_start), 32'h0);
        command(8'h30, 8'h40, 8'h20, 6'h20, 8'h70);

`ifdef UART_ALU_TIMEOUT_EN
        send_byte(8'h55);
        p0 = to_pulses;
        idle(20);
        check("timeout_pulses", 32'(to_pulses - p0), 32'd1);
        check("timeout_state", 32'(dbg_state), 32'(ST_WAIT_A));
        send_byte(8'h66);
        check("post_timeout_a", 32'(alu_a), 32'h66);
        idle(TO_CYCLES - 1);
        p0 = to_pulses;
        send_byte(8'h77);
        idle(2);
        check("expiry_byte_b", 32'(alu_b), 32'h77);
        check("expiry_state", 32'(dbg_state), 32'(ST_WAIT_OP));
        check("expiry_no_err", 32'(to_pulses - p0), 32'd0);
        exp_q.push_back('{a: 8'h66, b: 8'h77, op: 6'h20, res: 8'hDD});
`else
        send_byte(8'h55);
        p0 = to_pulses;
        idle(20);
        check("no_timeout_pulses", 32'(to_pulses - p0), 32'd0);
        check("no_timeout_state", 32'(dbg_state), 32'(ST_WAIT_B));
        send_byte(8'h66);
        exp_q.push_back('{a: 8'h55, b: 8'h66, op: 6'h20, res: 8'hBB});
`endif
        send_byte(8'h20);
        idle(2);
        pulse_tx_done();

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("drain", 32'(exp_q.size()), 32'd0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
